// File: rtl/rtc_bus_arbiter_if.sv
// Bundles the RTC bus arbiter source, bus and read-back signals.
// Latency: none, wiring only.
// Backpressure: none; sources hold req high until they are done.
interface rtc_bus_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int N_SRC  = 3
);
    logic [N_SRC-1:0]        req;
    logic [N_SRC*DATA_W-1:0] din;
    logic [DATA_W-1:0]       bus_in;
    logic                    rd_sample;
    logic [N_SRC-1:0]        gnt;
    logic [DATA_W-1:0]       bus_out;
    logic                    bus_oe;
    logic                    busy;
    logic [DATA_W-1:0]       rd_data;
    logic                    rd_valid;
    logic                    timeout;

    // Arbiter side
    modport slave (
        input  req, din, bus_in, rd_sample,
        output gnt, bus_out, bus_oe, busy, rd_data, rd_valid, timeout
    );

    // Source / bus side
    modport master (
        output req, din, bus_in, rd_sample,
        input  gnt, bus_out, bus_oe, busy, rd_data, rd_valid, timeout
    );
endinterface

// File: rtl/rtc_bus_arbiter.sv
// Fixed-priority arbiter sharing one RTC bus among N_SRC sources, with turnaround and hold timeout.
// Latency: grant and bus data one cycle after request; release gap TURN_CYC+1 cycles.
// Backpressure: requests wait while busy; over-long holders are cut off and masked until they drop req.
module rtc_bus_arbiter #(
    parameter int DATA_W      = 8,
    parameter int N_SRC       = 3,
    parameter int TURN_CYC    = 1,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    rtc_bus_arbiter_if.slave  bus
);

    localparam int IDX_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int HOLD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int TURN_W = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(TIMEOUT_CYC - 1);
    localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_armed;
    logic [IDX_W-1:0]    r_idx;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [TURN_W-1:0]   r_turn_cnt;
    logic [N_SRC-1:0]    r_mask;
    logic [N_SRC-1:0]    r_gnt;
    logic [DATA_W-1:0]   r_bus_out;
    logic                r_bus_oe;
    logic                r_timeout;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_rd_valid;

    state_t              w_state_nxt;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic [HOLD_W-1:0]   w_hold_nxt;
    logic [TURN_W-1:0]   w_turn_nxt;
    logic [N_SRC-1:0]    w_mask_nxt;
    logic [N_SRC-1:0]    w_gnt_nxt;
    logic [DATA_W-1:0]   w_bus_out_nxt;
    logic                w_bus_oe_nxt;
    logic                w_timeout_nxt;

    logic [N_SRC-1:0]    w_elig;
    logic                w_any;
    logic [IDX_W-1:0]    w_pick;
    logic [DATA_W-1:0]   w_pick_din;
    logic                w_cur_req;
    logic [DATA_W-1:0]   w_cur_din;

    // Masked-out sources (cut off by timeout) are invisible to arbitration.
    assign w_elig     = bus.req & ~r_mask;
    assign w_pick_din = bus.din[w_pick * DATA_W +: DATA_W];
    assign w_cur_req  = bus.req[r_idx];
    assign w_cur_din  = bus.din[r_idx * DATA_W +: DATA_W];

    // Lowest eligible index wins; scanning downward leaves the lowest one last.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_any  = 1'b1;
                w_pick = IDX_W'(i);
            end
        end
    end

    // Next state plus next registered outputs; every output defaults to the idle value.
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_hold_nxt    = r_hold_cnt;
        w_turn_nxt    = r_turn_cnt;
        w_mask_nxt    = r_mask & bus.req;
        w_gnt_nxt     = '0;
        w_bus_out_nxt = '0;
        w_bus_oe_nxt  = 1'b0;
        w_timeout_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // r_armed keeps the first edge after reset grant-free.
                if (r_armed && w_any) begin
                    w_state_nxt   = ST_GRANT;
                    w_idx_nxt     = w_pick;
                    w_hold_nxt    = '0;
                    w_gnt_nxt     = N_SRC'(1) << w_pick;
                    w_bus_out_nxt = w_pick_din;
                    w_bus_oe_nxt  = 1'b1;
                end
            end
            ST_GRANT: begin
                if (!w_cur_req) begin
                    // A voluntary drop wins over a coincident terminal count.
                    w_state_nxt = ST_TURN;
                    w_turn_nxt  = '0;
                end else if (r_hold_cnt == HOLD_LAST) begin
                    w_state_nxt       = ST_TURN;
                    w_turn_nxt        = '0;
                    w_timeout_nxt     = 1'b1;
                    w_mask_nxt[r_idx] = 1'b1;
                end else begin
                    w_hold_nxt    = r_hold_cnt + 1'b1;
                    w_gnt_nxt     = r_gnt;
                    w_bus_out_nxt = w_cur_din;
                    w_bus_oe_nxt  = 1'b1;
                end
            end
            ST_TURN: begin
                if (r_turn_cnt == TURN_LAST) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_turn_nxt = r_turn_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state, counters, mask and registered bus outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_hold_cnt <= '0;
            r_turn_cnt <= '0;
            r_mask     <= '0;
            r_gnt      <= '0;
            r_bus_out  <= '0;
            r_bus_oe   <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_turn_cnt <= w_turn_nxt;
            r_mask     <= w_mask_nxt;
            r_gnt      <= w_gnt_nxt;
            r_bus_out  <= w_bus_out_nxt;
            r_bus_oe   <= w_bus_oe_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    // Arms arbitration one edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
        end
    end

    // Read-back capture only while we are not driving the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else if (bus.rd_sample && !r_bus_oe) begin
            r_rd_data  <= bus.bus_in;
            r_rd_valid <= 1'b1;
        end else begin
            r_rd_valid <= 1'b0;
        end
    end

    assign bus.gnt      = r_gnt;
    assign bus.bus_out  = r_bus_out;
    assign bus.bus_oe   = r_bus_oe;
    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
    assign bus.timeout  = r_timeout;

    // Grant is never more than one-hot.
    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(r_gnt));

    // Output enable tracks the grant exactly.
    a_oe_match: assert property (@(posedge clk) disable iff (!rst_n) r_bus_oe == (|r_gnt));

    // Timeout pulse coincides with the grant being gone.
    a_timeout_nognt: assert property (@(posedge clk) disable iff (!rst_n) r_timeout |-> (r_gnt == '0));

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
module tb_rtc_bus_arbiter;

    logic clk;
    logic rst_a, rst_b, rst_c;
    int   n_pass;
    int   n_total;

    // a: defaults; b: short timeout; c: wide parameter sweep
    rtc_bus_arbiter_if #(.DATA_W(8), .N_SRC(3)) a_if ();
    rtc_bus_arbiter_if #(.DATA_W(8), .N_SRC(3)) b_if ();
    rtc_bus_arbiter_if #(.DATA_W(4), .N_SRC(5)) c_if ();

    rtc_bus_arbiter #(.DATA_W(8), .N_SRC(3), .TURN_CYC(1), .TIMEOUT_CYC(255))
        u_a (.clk(clk), .rst_n(rst_a), .bus(a_if));
    rtc_bus_arbiter #(.DATA_W(8), .N_SRC(3), .TURN_CYC(1), .TIMEOUT_CYC(4))
        u_b (.clk(clk), .rst_n(rst_b), .bus(b_if));
    rtc_bus_arbiter #(.DATA_W(4), .N_SRC(5), .TURN_CYC(3), .TIMEOUT_CYC(255))
        u_c (.clk(clk), .rst_n(rst_c), .bus(c_if));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick(); tick();
        n_total++; if (a_if.gnt !== 3'b000) $display("FAIL rst_gnt got %b want 000", a_if.gnt); else n_pass++;
        n_total++; if (a_if.bus_out !== 8'h00) $display("FAIL rst_bus_out got %h want 00", a_if.bus_out); else n_pass++;
        n_total++; if (a_if.bus_oe !== 1'b0) $display("FAIL rst_bus_oe got %b want 0", a_if.bus_oe); else n_pass++;
        n_total++; if (a_if.busy !== 1'b0) $display("FAIL rst_busy got %b want 0", a_if.busy); else n_pass++;
        n_total++; if (a_if.rd_data !== 8'h00) $display("FAIL rst_rd_data got %h want 00", a_if.rd_data); else n_pass++;
        n_total++; if (a_if.rd_valid !== 1'b0) $display("FAIL rst_rd_valid got %b want 0", a_if.rd_valid); else n_pass++;
        n_total++; if (a_if.timeout !== 1'b0) $display("FAIL rst_timeout got %b want 0", a_if.timeout); else n_pass++;
        a_if.req = 3'b001;
        a_if.din[0 +: 8] = 8'h11;
        tick();
        n_total++; if (a_if.gnt !== 3'b000) $display("FAIL rst_held_gnt got %b want 000", a_if.gnt); else n_pass++;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        tick();
        n_total++; if (a_if.gnt !== 3'b000) $display("FAIL first_edge_gnt got %b want 000", a_if.gnt); else n_pass++;
        tick();
        n_total++; if (a_if.gnt !== 3'b001) $display("FAIL second_edge_gnt got %b want 001", a_if.gnt); else n_pass++;
        a_if.req = 3'b000;
        tick(); tick();
        n_total++; if (a_if.busy !== 1'b0) $display("FAIL post_reset_idle busy got %b want 0", a_if.busy); else n_pass++;
    endtask

    task automatic test_priority();
        a_if.din[8 +: 8]  = 8'hA5;
        a_if.din[16 +: 8] = 8'h3C;
        a_if.req = 3'b110;
        tick();
        n_total++; if (a_if.gnt !== 3'b010) $display("FAIL prio_gnt got %b want 010", a_if.gnt); else n_pass++;
        n_total++; if (a_if.bus_out !== 8'hA5) $display("FAIL prio_bus_out got %h want a5", a_if.bus_out); else n_pass++;
        n_total++; if (a_if.bus_oe !== 1'b1) $display("FAIL prio_bus_oe got %b want 1", a_if.bus_oe); else n_pass++;
        n_total++; if (a_if.busy !== 1'b1) $display("FAIL prio_busy got %b want 1", a_if.busy); else n_pass++;
        a_if.din[8 +: 8] = 8'h5A;
        tick();
        n_total++; if (a_if.bus_out !== 8'h5A) $display("FAIL grant_follow_din got %h want 5a", a_if.bus_out); else n_pass++;
    endtask

    task automatic test_no_preempt();
        a_if.req = 3'b111;
        tick();
        n_total++; if (a_if.gnt !== 3'b010) $display("FAIL no_preempt_gnt got %b want 010", a_if.gnt); else n_pass++;
        a_if.req = 3'b101;
        tick();
        n_total++; if (a_if.gnt !== 3'b000) $display("FAIL release_gnt got %b want 000", a_if.gnt); else n_pass++;
        n_total++; if (a_if.bus_oe !== 1'b0) $display("FAIL release_oe got %b want 0", a_if.bus_oe); else n_pass++;
        n_total++; if (a_if.bus_out !== 8'h00) $display("FAIL release_bus_out got %h want 00", a_if.bus_out); else n_pass++;
        n_total++; if (a_if.busy !== 1'b1) $display("FAIL turn_busy got %b want 1", a_if.busy); else n_pass++;
        tick();
        n_total++; if (a_if.gnt !== 3'b000) $display("FAIL gap_gnt got %b want 000", a_if.gnt); else n_pass++;
        n_total++; if (a_if.busy !== 1'b0) $display("FAIL gap_idle_busy got %b want 0", a_if.busy); else n_pass++;
        tick();
        n_total++; if (a_if.gnt !== 3'b001) $display("FAIL regrant_gnt got %b want 001", a_if.gnt); else n_pass++;
        n_total++; if (a_if.bus_out !== 8'h11) $display("FAIL regrant_bus_out got %h want 11", a_if.bus_out); else n_pass++;
        a_if.req = 3'b000;
        tick(); tick();
    endtask

    task automatic test_read();
        a_if.bus_in = 8'h59;
        a_if.rd_sample = 1'b1;
        tick();
        n_total++; if (a_if.rd_data !== 8'h59) $display("FAIL rd_idle_data got %h want 59", a_if.rd_data); else n_pass++;
        n_total++; if (a_if.rd_valid !== 1'b1) $display("FAIL rd_idle_valid got %b want 1", a_if.rd_valid); else n_pass++;
        a_if.rd_sample = 1'b0;
        tick();
        n_total++; if (a_if.rd_valid !== 1'b0) $display("FAIL rd_pulse_end got %b want 0", a_if.rd_valid); else n_pass++;
        a_if.req = 3'b100;
        tick();
        a_if.bus_in = 8'h77;
        a_if.rd_sample = 1'b1;
        tick();
        n_total++; if (a_if.rd_valid !== 1'b0) $display("FAIL rd_grant_valid got %b want 0", a_if.rd_valid); else n_pass++;
        n_total++; if (a_if.rd_data !== 8'h59) $display("FAIL rd_grant_data got %h want 59", a_if.rd_data); else n_pass++;
        a_if.rd_sample = 1'b0;
    endtask

    task automatic test_async_reset();
        a_if.din[16 +: 8] = 8'hFF;
        tick();
        n_total++; if (a_if.bus_out !== 8'hFF) $display("FAIL pre_reset_bus_out got %h want ff", a_if.bus_out); else n_pass++;
        #2 rst_a = 1'b0;
        #1;
        n_total++; if (a_if.gnt !== 3'b000) $display("FAIL arst_gnt got %b want 000", a_if.gnt); else n_pass++;
        n_total++; if (a_if.bus_out !== 8'h00) $display("FAIL arst_bus_out got %h want 00", a_if.bus_out); else n_pass++;
        n_total++; if (a_if.bus_oe !== 1'b0) $display("FAIL arst_oe got %b want 0", a_if.bus_oe); else n_pass++;
        n_total++; if (a_if.busy !== 1'b0) $display("FAIL arst_busy got %b want 0", a_if.busy); else n_pass++;
        n_total++; if (a_if.rd_data !== 8'h00) $display("FAIL arst_rd_data got %h want 00", a_if.rd_data); else n_pass++;
        a_if.req = 3'b000;
        tick();
        rst_a = 1'b1;
        tick();
    endtask

    task automatic test_timeout();
        b_if.req = 3'b100;
        tick();
        n_total++; if (b_if.gnt !== 3'b100) $display("FAIL to_gnt_first got %b want 100", b_if.gnt); else n_pass++;
        tick(); tick(); tick();
        n_total++; if (b_if.gnt !== 3'b100) $display("FAIL to_gnt_fourth got %b want 100", b_if.gnt); else n_pass++;
        n_total++; if (b_if.timeout !== 1'b0) $display("FAIL to_early_pulse got %b want 0", b_if.timeout); else n_pass++;
        tick();
        n_total++; if (b_if.gnt !== 3'b000) $display("FAIL to_drop_gnt got %b want 000", b_if.gnt); else n_pass++;
        n_total++; if (b_if.timeout !== 1'b1) $display("FAIL to_pulse got %b want 1", b_if.timeout); else n_pass++;
        tick();
        n_total++; if (b_if.timeout !== 1'b0) $display("FAIL to_pulse_width got %b want 0", b_if.timeout); else n_pass++;
        tick(); tick();
        n_total++; if (b_if.gnt !== 3'b000) $display("FAIL to_masked_gnt got %b want 000", b_if.gnt); else n_pass++;
        b_if.req = 3'b000;
        tick();
        b_if.req = 3'b100;
        tick();
        n_total++; if (b_if.gnt !== 3'b100) $display("FAIL to_unmask_gnt got %b want 100", b_if.gnt); else n_pass++;
    endtask

    task automatic test_drop_at_terminal();
        tick(); tick(); tick();
        n_total++; if (b_if.gnt !== 3'b100) $display("FAIL tc_hold_gnt got %b want 100", b_if.gnt); else n_pass++;
        b_if.req = 3'b000;
        tick();
        n_total++; if (b_if.gnt !== 3'b000) $display("FAIL tc_drop_gnt got %b want 000", b_if.gnt); else n_pass++;
        n_total++; if (b_if.timeout !== 1'b0) $display("FAIL tc_no_pulse got %b want 0", b_if.timeout); else n_pass++;
        b_if.req = 3'b100;
        tick(); tick();
        n_total++; if (b_if.gnt !== 3'b100) $display("FAIL tc_no_mask_gnt got %b want 100", b_if.gnt); else n_pass++;
        b_if.req = 3'b000;
        tick(); tick();
    endtask

    task automatic test_sweep();
        c_if.din[4 +: 4]  = 4'hC;
        c_if.din[12 +: 4] = 4'h7;
        c_if.din[16 +: 4] = 4'h9;
        c_if.req = 5'b11000;
        tick();
        n_total++; if (c_if.gnt !== 5'b01000) $display("FAIL sw_gnt got %b want 01000", c_if.gnt); else n_pass++;
        n_total++; if (c_if.bus_out !== 4'h7) $display("FAIL sw_bus_out got %h want 7", c_if.bus_out); else n_pass++;
        c_if.req = 5'b10110;
        tick();
        n_total++; if (c_if.gnt !== 5'b00000) $display("FAIL sw_release_gnt got %b want 00000", c_if.gnt); else n_pass++;
        tick(); tick();
        n_total++; if (c_if.busy !== 1'b1) $display("FAIL sw_turn3_busy got %b want 1", c_if.busy); else n_pass++;
        n_total++; if (c_if.gnt !== 5'b00000) $display("FAIL sw_turn3_gnt got %b want 00000", c_if.gnt); else n_pass++;
        tick();
        n_total++; if (c_if.busy !== 1'b0) $display("FAIL sw_idle_busy got %b want 0", c_if.busy); else n_pass++;
        tick();
        n_total++; if (c_if.gnt !== 5'b00010) $display("FAIL sw_regrant_gnt got %b want 00010", c_if.gnt); else n_pass++;
        n_total++; if (c_if.bus_out !== 4'hC) $display("FAIL sw_regrant_bus_out got %h want c", c_if.bus_out); else n_pass++;
        n_total++; if (c_if.bus_oe !== 1'b1) $display("FAIL sw_regrant_oe got %b want 1", c_if.bus_oe); else n_pass++;
        c_if.req = 5'b00000;
        tick();
    endtask

    initial begin
        clk = 1'b0;
        n_pass = 0;
        n_total = 0;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        a_if.req = '0; a_if.din = '0; a_if.bus_in = '0; a_if.rd_sample = 1'b0;
        b_if.req = '0; b_if.din = '0; b_if.bus_in = '0; b_if.rd_sample = 1'b0;
        c_if.req = '0; c_if.din = '0; c_if.bus_in = '0; c_if.rd_sample = 1'b0;
        test_reset();
        test_priority();
        test_no_preempt();
        test_read();
        test_async_reset();
        test_timeout();
        test_drop_at_terminal();
        test_sweep();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
